itree_channel_scheduler: RTL and testbench
==========================================

Name: itree_channel_scheduler

Overview:
Shares one isolation-tree evaluator (8-bit data_input/data_valid in, anomaly_detected out) among NUM_CH sensor channels. The block sequences one sample at a time through the evaluator and arbitrates between channels round-robin. It returns a tagged per-sample result and keeps a sticky per-channel alarm plus a saturating global anomaly counter. It sits between the sensor front-ends and the evaluator.

Parameters:
NUM_CH, 4, number of sensor channels (2..16)
DATA_W, 8, sample width; matches evaluator data_input
EVAL_LAT, 2, cycles from evaluator data_valid pulse to valid anomaly_detected (>=1)
CNT_W, 8, width of anomaly_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
ch_valid  in  NUM_CH  per-channel sample valid
ch_data  in  NUM_CH*DATA_W  per-channel samples, channel i at bits [i*DATA_W +: DATA_W]
ch_ready  out  NUM_CH  one-hot accept strobe
eval_data  out  DATA_W  sample to evaluator data_input
eval_valid  out  1  single-cycle pulse to evaluator data_valid
eval_anomaly  in  1  evaluator anomaly_detected
result_valid  out  1  single-cycle result strobe
result_ch  out  clog2(NUM_CH)  channel of the reported result
result_anomaly  out  1  anomaly verdict of the reported result
ch_alarm  out  NUM_CH  sticky per-channel alarm
alarm_clear  in  NUM_CH  per-channel alarm clear
anomaly_count  out  CNT_W  saturating count of anomalous results
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, eval_valid 0, eval_data 0, result_valid 0, result_ch 0, result_anomaly 0, ch_alarm 0, anomaly_count 0, rr pointer 0, lat counter 0.
- Reset mid-operation drops the in-flight sample. No result_valid is issued and eval_valid drops the following cycle.
- FSM states: IDLE, ISSUE, WAIT, REPORT.
- IDLE: grant goes to the first channel with ch_valid=1, searching from rr_ptr upward with wrap at NUM_CH-1 -> 0.
  - ch_ready is combinational: it is one-hot on the granted channel, only in IDLE, and only if that channel's ch_valid=1. Otherwise it is all-zero.
  - On accept, latch ch_data of the granted channel and its index, set rr_ptr = granted+1 (mod NUM_CH), then go to ISSUE.
  - With no valid channel, stay in IDLE.
- ISSUE: eval_valid=1 for exactly one cycle with eval_data = latched sample. Load lat counter = 1, then go to WAIT.
- WAIT: on each cycle where counter != EVAL_LAT, increment it. When counter == EVAL_LAT, register eval_anomaly and go to REPORT.
  - eval_anomaly is ignored in all other cycles.
- REPORT: result_valid=1 for one cycle with result_ch and result_anomaly, then go to IDLE.
  - If the anomaly bit is set: set ch_alarm[result_ch] and increment anomaly_count, saturating at 2^CNT_W-1 (no wrap).
- Timing: accept at cycle T, eval_valid at T+1, sample eval_anomaly at T+1+EVAL_LAT, result_valid at T+2+EVAL_LAT, next accept possible at T+3+EVAL_LAT.
- eval_data holds its value outside ISSUE (no glitching needed). It is only meaningful while eval_valid=1.
- alarm_clear[i] clears ch_alarm[i] next cycle. If it coincides with a REPORT set of the same channel, the set wins. It has no effect on anomaly_count.
- ch_valid/ch_data may change freely when ch_ready=0. Data is captured only on ch_valid & ch_ready.

Optional Feature:
ITREE_SCHED_PRIORITY_EN
- Defined: arbitration is fixed-priority, with the lowest channel index winning. rr_ptr is unused and held at 0.
- Undefined: round-robin as described above.
- All other timing is identical in both builds.

Test Plan:
- Single sample: ch1 valid, data 0xAA, evaluator model returns 0 at EVAL_LAT=2 -> ch_ready=0010 for 1 cycle; eval_valid at T+1 with eval_data 0xAA; result_valid at T+4 with result_ch=1, result_anomaly=0; ch_alarm=0000; count=0.
- Anomaly path: ch2 data 0xCC, model returns 1 -> result_anomaly=1, ch_alarm=0100, anomaly_count=1. Then alarm_clear[2] pulse -> ch_alarm=0000 and count stays 1.
- Round-robin fairness: all four channels held valid for 4 samples -> grant order 0,1,2,3. With the macro defined -> grants 0,0,0,0.
- Saturation: CNT_W=2, five anomalous results -> anomaly_count sequence 1,2,3,3,3.
- Clear/set collision: alarm_clear[0] asserted in the REPORT cycle of an anomalous ch0 result -> ch_alarm[0]=1 afterwards.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> no result_valid; busy=0, ch_alarm=0, count=0 next cycle; a new sample is accepted normally afterwards.

Source files
------------

// File: rtl/itree_channel_scheduler.sv
// Shares one isolation-tree evaluator among NUM_CH channels: grant, issue, wait EVAL_LAT, report, repeat.
// Latency: accept T, eval_valid T+1, eval_anomaly sampled T+1+EVAL_LAT, result_valid T+2+EVAL_LAT.
// Backpressure: ch_ready is a one-hot accept strobe only while IDLE. Define ITREE_SCHED_PRIORITY_EN for fixed priority.

module itree_channel_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 8,
   parameter int EVAL_LAT = 2,
   parameter int CNT_W    = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   output logic [NUM_CH-1:0]          ch_ready,
   output logic [DATA_W-1:0]          eval_data,
   output logic                       eval_valid,
   input  logic                       eval_anomaly,
   output logic                       result_valid,
   output logic [$clog2(NUM_CH)-1:0]  result_ch,
   output logic                       result_anomaly,
   output logic [NUM_CH-1:0]          ch_alarm,
   input  logic [NUM_CH-1:0]          alarm_clear,
   output logic [CNT_W-1:0]           anomaly_count,
   output logic                       busy
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int LAT_W = $clog2(EVAL_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t              state_q;
   logic [CH_W-1:0]     rr_ptr_q;
   logic [LAT_W-1:0]    lat_q;
   logic [CH_W-1:0]     ch_q;
   logic [DATA_W-1:0]   eval_data_q;
   logic                eval_valid_q;
   logic                result_valid_q;
   logic [CH_W-1:0]     result_ch_q;
   logic                result_anomaly_q;
   logic [NUM_CH-1:0]   alarm_q;
   logic [NUM_CH-1:0]   alarm_d;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;

   logic                grant_found;
   logic [CH_W-1:0]     grant_idx;
   logic                report_hit;

   // Channel index base+off folded back into 0..NUM_CH-1 (off < NUM_CH, base < NUM_CH).
   function automatic int wrap_add(input int base, input int off);
      int s;
      s = base + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return s;
   endfunction

   // Find the first valid channel searching upward from rr_ptr; in the priority build rr_ptr stays 0,
   // so the same search degenerates to lowest-index-wins. Iterating downward lets the smallest offset win.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_valid[wrap_add(int'(rr_ptr_q), i)]) begin
            grant_found = 1'b1;
            grant_idx   = CH_W'(wrap_add(int'(rr_ptr_q), i));
         end
      end
   end

   // Accept strobe: one-hot on the granted channel, only while idle and only when that channel is valid.
   always_comb begin
      ch_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_ready[i] = (state_q == S_IDLE) && grant_found && (grant_idx == CH_W'(i));
      end
   end

`ifndef ITREE_SCHED_PRIORITY_EN
   logic [CH_W-1:0] rr_next;

   // Pointer moves to the channel after the one just granted, wrapping at NUM_CH-1.
   always_comb begin
      rr_next = '0;
      if (grant_idx != CH_W'(NUM_CH - 1)) rr_next = grant_idx + CH_W'(1);
   end
`endif

   assign report_hit = (state_q == S_REPORT) && result_anomaly_q;

   // Sticky alarms and saturating anomaly counter; a report set beats a same-cycle clear.
   always_comb begin
      alarm_d = alarm_q & ~alarm_clear;
      count_d = count_q;
      if (report_hit) begin
         alarm_d[result_ch_q] = 1'b1;
         if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
      end
   end

   // Sequencer: IDLE -> ISSUE -> WAIT (EVAL_LAT cycles from the pulse) -> REPORT, all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         rr_ptr_q         <= '0;
         lat_q            <= '0;
         ch_q             <= '0;
         eval_data_q      <= '0;
         eval_valid_q     <= 1'b0;
         result_valid_q   <= 1'b0;
         result_ch_q      <= '0;
         result_anomaly_q <= 1'b0;
         alarm_q          <= '0;
         count_q          <= '0;
      end else begin
         eval_valid_q   <= 1'b0;
         result_valid_q <= 1'b0;
         alarm_q        <= alarm_d;
         count_q        <= count_d;
         case (state_q)
            S_IDLE: begin
               if (grant_found) begin
                  eval_data_q  <= ch_data[grant_idx*DATA_W +: DATA_W];
                  ch_q         <= grant_idx;
`ifdef ITREE_SCHED_PRIORITY_EN
                  rr_ptr_q     <= '0;
`else
                  rr_ptr_q     <= rr_next;
`endif
                  eval_valid_q <= 1'b1;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               lat_q   <= LAT_W'(1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_q == LAT_W'(EVAL_LAT)) begin
                  result_anomaly_q <= eval_anomaly;
                  result_ch_q      <= ch_q;
                  result_valid_q   <= 1'b1;
                  state_q          <= S_REPORT;
               end else begin
                  lat_q <= lat_q + LAT_W'(1);
               end
            end
            S_REPORT: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign eval_data      = eval_data_q;
   assign eval_valid     = eval_valid_q;
   assign result_valid   = result_valid_q;
   assign result_ch      = result_ch_q;
   assign result_anomaly = result_anomaly_q;
   assign ch_alarm       = alarm_q;
   assign anomaly_count  = count_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_itree_channel_scheduler.sv
// Directed bench for itree_channel_scheduler with a small evaluator model (EVAL_LAT=2).
// The model drives the inverse verdict outside the sampling cycle so mistimed sampling shows up.
// Counter width is 2 so saturation is reachable in a few samples.

module tb_itree_channel_scheduler;

   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 8;
   localparam int EVAL_LAT = 2;
   localparam int CNT_W    = 2;
`ifdef ITREE_SCHED_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic                       clk;
   logic                       reset;
   logic [NUM_CH-1:0]          ch_valid;
   logic [NUM_CH*DATA_W-1:0]   ch_data;
   logic [NUM_CH-1:0]          ch_ready;
   logic [DATA_W-1:0]          eval_data;
   logic                       eval_valid;
   logic                       eval_anomaly;
   logic                       result_valid;
   logic [1:0]                 result_ch;
   logic                       result_anomaly;
   logic [NUM_CH-1:0]          ch_alarm;
   logic [NUM_CH-1:0]          alarm_clear;
   logic [CNT_W-1:0]           anomaly_count;
   logic                       busy;

   int   checks = 0;
   int   errors = 0;
   bit   verdict;
   logic [1:0] pipe;

   itree_channel_scheduler #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .EVAL_LAT(EVAL_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
      .eval_data(eval_data), .eval_valid(eval_valid), .eval_anomaly(eval_anomaly),
      .result_valid(result_valid), .result_ch(result_ch), .result_anomaly(result_anomaly),
      .ch_alarm(ch_alarm), .alarm_clear(alarm_clear),
      .anomaly_count(anomaly_count), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Evaluator model: verdict appears exactly EVAL_LAT cycles after the data_valid pulse.
   always @(posedge clk) begin
      if (reset) pipe <= 2'b00;
      else       pipe <= {pipe[0], eval_valid};
   end
   assign eval_anomaly = pipe[1] ? verdict : ~verdict;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full single-sample timeline; entered and left just after a falling edge with the DUT idle.
   task automatic run_one(input int ch, input logic [7:0] data, input bit v,
                          input logic [3:0] exp_alarm, input logic [1:0] exp_cnt,
                          input bit clr_in_report);
      logic [3:0] onehot;
      onehot = 4'b0001 << ch;
      ch_data = $urandom;
      ch_data[ch*8 +: 8] = data;
      ch_valid = onehot;
      verdict  = v;
      #1 chk("ready_onehot", ch_ready, onehot);
      @(negedge clk);
      ch_valid = '0;
      ch_data  = $urandom;
      chk("eval_valid_T1", eval_valid, 1);
      chk("eval_data_T1", eval_data, data);
      chk("ready_low_T1", ch_ready, 0);
      @(negedge clk);
      chk("eval_valid_T2", eval_valid, 0);
      @(negedge clk);
      chk("result_early_T3", result_valid, 0);
      @(negedge clk);
      chk("result_valid_T4", result_valid, 1);
      chk("result_ch_T4", result_ch, ch);
      chk("result_anom_T4", result_anomaly, v);
      if (clr_in_report) alarm_clear = onehot;
      @(negedge clk);
      alarm_clear = '0;
      chk("result_drop_T5", result_valid, 0);
      chk("busy_T5", busy, 0);
      chk("alarm_T5", ch_alarm, exp_alarm);
      chk("count_T5", anomaly_count, exp_cnt);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      int   exp_g;
      bit   seen;
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      reset = 1'b1; ch_valid = '0; ch_data = '0; alarm_clear = '0; verdict = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_eval_valid", eval_valid, 0);
      chk("rst_eval_data", eval_data, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_ch", result_ch, 0);
      chk("rst_result_anom", result_anomaly, 0);
      chk("rst_alarm", ch_alarm, 0);
      chk("rst_count", anomaly_count, 0);
      chk("rst_ready", ch_ready, 0);

      // Single clean sample on ch1
      run_one(1, 8'hAA, 1'b0, 4'b0000, 2'd0, 1'b0);

      // Anomalous sample on ch2, then clear its alarm
      run_one(2, 8'hCC, 1'b1, 4'b0100, 2'd1, 1'b0);
      alarm_clear = 4'b0100;
      @(negedge clk);
      alarm_clear = '0;
      chk("clear_alarm", ch_alarm, 4'b0000);
      chk("clear_keeps_count", anomaly_count, 1);

      // Clear collides with the report of an anomalous ch0 sample: set wins
      run_one(0, 8'h0F, 1'b1, 4'b0001, 2'd2, 1'b1);

      // Fairness: all channels held valid for four back-to-back samples from a fresh pointer
      do_reset();
      chk("rr_rst_alarm", ch_alarm, 0);
      chk("rr_rst_count", anomaly_count, 0);
      ch_valid = 4'hF;
      ch_data  = {8'h43, 8'h32, 8'h21, 8'h10};
      verdict  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_g = PRIO ? 0 : k;
         #1 chk("rr_grant", ch_ready, 4'b0001 << exp_g);
         @(negedge clk);
         chk("rr_eval_data", eval_data, 8'h10 + 8'h11 * exp_g);
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
         chk("rr_result_ch", result_ch, exp_g);
         @(negedge clk);
      end
      ch_valid = '0;

      // Saturation of the 2-bit counter
      for (int k = 0; k < 5; k++) begin
         run_one(3, 8'h30 + 8'(k), 1'b1, 4'b1000, sat_exp[k], 1'b0);
      end

      // Reset during WAIT drops the sample
      ch_data  = '0;
      ch_data[15:8] = 8'hAA;
      ch_valid = 4'b0010;
      verdict  = 1'b1;
      @(negedge clk);
      ch_valid = '0;
      @(negedge clk);
      chk("midwait_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midwait_busy_after", busy, 0);
      chk("midwait_eval_valid", eval_valid, 0);
      chk("midwait_alarm", ch_alarm, 0);
      chk("midwait_count", anomaly_count, 0);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (result_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("midwait_no_result", seen, 0);
      run_one(1, 8'h5A, 1'b0, 4'b0000, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
